// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter sharing one SPI master among NREQ requesters.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   req, req_data       - per-requester request level and packed TX words
//   gnt, done, err      - one-hot grant, per-requester completion pulse, timeout pulse
//   rsp_data            - RX word of the last completed transaction
//   m_start, m_data_in  - start and TX word towards the SPI master
//   m_busy, m_cs_n,
//   m_data_out          - SPI master status and RX word
//   dev_cs_n            - per-device chip selects (active-low), steered by gnt
module spi_arbiter #(
    parameter int unsigned NREQ       = 4,
    parameter int unsigned DATALENGTH = 16,
    parameter int unsigned TIMEOUT    = 1023
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NREQ-1:0]              req,
    input  logic [NREQ*DATALENGTH-1:0]   req_data,
    output logic [NREQ-1:0]              gnt,
    output logic [NREQ-1:0]              done,
    output logic                         err,
    output logic [DATALENGTH-1:0]        rsp_data,
    output logic                         m_start,
    output logic [DATALENGTH-1:0]        m_data_in,
    input  logic                         m_busy,
    input  logic                         m_cs_n,
    input  logic [DATALENGTH-1:0]        m_data_out,
    output logic [NREQ-1:0]              dev_cs_n
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_XFER  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic [NREQ-1:0]        gnt_d, done_d;
    logic                   err_d, m_start_d;
    logic [DATALENGTH-1:0]  rsp_d, mdi_d;

    logic [DATALENGTH-1:0]  req_word [NREQ];
    logic                   req_any;
    logic [IDX_W-1:0]       sel_idx;
    int unsigned            cand;
    logic                   timeout_hit;
    logic                   xfer_fin;

    // Unpack the flat request bus into per-requester words
    for (genvar g = 0; g < NREQ; g++) begin : g_slice
        assign req_word[g] = req_data[g*DATALENGTH +: DATALENGTH];
    end

    // Round-robin search: first set req bit at or after last_q+1, wrapping
    always_comb begin
        req_any = 1'b0;
        sel_idx = '0;
        cand    = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(last_q) + 32'd1 + i) % NREQ;
            if (!req_any && req[IDX_W'(cand)]) begin
                req_any = 1'b1;
                sel_idx = IDX_W'(cand);
            end
        end
    end

    // Counter is at TIMEOUT-1 in the cycle whose closing edge would reach TIMEOUT
    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));
    // Master still busy but chip select released: the word is complete
    assign xfer_fin    = m_busy && m_cs_n;

    // Chip select steering follows the live grant
    assign dev_cs_n = ~gnt | {NREQ{m_cs_n}};

    // State register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            last_q    <= IDX_W'(NREQ - 1);
            cnt_q     <= '0;
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            m_start   <= 1'b0;
            m_data_in <= '0;
            rsp_data  <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            gnt       <= gnt_d;
            done      <= done_d;
            err       <= err_d;
            m_start   <= m_start_d;
            m_data_in <= mdi_d;
            rsp_data  <= rsp_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_any) state_d = S_START;
            S_START: begin
                if (timeout_hit)  state_d = S_DRAIN;
                else if (m_busy)  state_d = S_XFER;
            end
            S_XFER: begin
                if (xfer_fin || timeout_hit) state_d = S_DRAIN;
            end
            S_DRAIN: if (!m_busy) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        gnt_d     = gnt;
        done_d    = '0;
        err_d     = 1'b0;
        m_start_d = m_start;
        rsp_d     = rsp_data;
        mdi_d     = m_data_in;
        last_d    = last_q;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                m_start_d = 1'b0;
                if (req_any) begin
                    gnt_d     = NREQ'(1) << sel_idx;
                    mdi_d     = req_word[sel_idx];
                    last_d    = sel_idx;
                    m_start_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            S_START: begin
                if (timeout_hit) begin
                    err_d     = 1'b1;
                    m_start_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_XFER: begin
                // A completed word takes priority over a coincident timeout
                if (xfer_fin) begin
                    rsp_d     = m_data_out;
                    done_d    = gnt;
                    m_start_d = 1'b0;
                end else if (timeout_hit) begin
                    err_d     = 1'b1;
                    m_start_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                m_start_d = 1'b0;
                if (!m_busy) gnt_d = '0;
            end
            default: begin
                gnt_d     = '0;
                m_start_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Testbench for spi_arbiter: SPI master model, scoreboard of expected completions,
// table of arbitration vectors plus hand-written timeout, reset and data-hold sequences.
module tb_spi_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 16;
    localparam int unsigned TMO  = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]   gnt, done, dev_cs_n;
    logic              err, m_start;
    logic [DW-1:0]     rsp_data, m_data_in;
    logic              m_busy = 1'b0;
    logic              m_cs_n = 1'b1;
    logic [DW-1:0]     m_data_out = '0;

    spi_arbiter #(.NREQ(NREQ), .DATALENGTH(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .gnt(gnt), .done(done), .err(err), .rsp_data(rsp_data),
        .m_start(m_start), .m_data_in(m_data_in), .m_busy(m_busy),
        .m_cs_n(m_cs_n), .m_data_out(m_data_out), .dev_cs_n(dev_cs_n)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]    req;
        logic [NREQ*DW-1:0] data;
        int unsigned        exp_idx;
    } vec_t;

    typedef struct {
        logic        is_err;
        int unsigned idx;
        logic [DW-1:0] tx;
        logic [DW-1:0] rsp;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   completions = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic logic [NREQ-1:0] onehot(input int unsigned i);
        logic [NREQ-1:0] r;
        r = NREQ'(1) << i;
        return r;
    endfunction

    function automatic logic [DW-1:0] slave_of(input logic [DW-1:0] tx);
        return tx ^ 16'h9999;
    endfunction

    // SPI master model: busy + CS low the cycle after start, CS high after 3 cycles, then idle
    logic [DW-1:0] mosi = '0;
    int            mst_st = 0;
    int            mst_cnt = 0;
    bit            master_dead = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            m_busy = 1'b0; m_cs_n = 1'b1; m_data_out = '0; mst_st = 0;
        end else begin
            case (mst_st)
                0: if (m_start && !master_dead) begin
                    m_busy = 1'b1; m_cs_n = 1'b0; mosi = m_data_in; mst_cnt = 3; mst_st = 1;
                end
                1: begin
                    mst_cnt--;
                    if (mst_cnt == 0) begin
                        m_cs_n = 1'b1; m_data_out = slave_of(mosi); mst_st = 2;
                    end
                end
                default: begin
                    m_busy = 1'b0; mst_st = 0;
                end
            endcase
        end
    end

    // Monitor: sampled 1ns after each rising edge
    int unsigned     cyc = 0;
    int unsigned     start_cyc = 0;
    int unsigned     last_done_cyc = 0;
    bit              have_done = 1'b0;
    logic [NREQ-1:0] prev_gnt = '0;
    logic            prev_mstart = 1'b0;
    logic [DW-1:0]   rsp_hold = '0;
    logic [NREQ-1:0] exp_cs;
    exp_t            e;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (reset) begin
            prev_gnt = '0; prev_mstart = 1'b0; have_done = 1'b0; rsp_hold = '0;
        end else begin
            if (m_cs_n) begin
                check("dev_cs_n_idle", dev_cs_n, 4'hF);
            end else if (sb.size() > 0) begin
                exp_cs = ~onehot(sb[0].idx);
                check("dev_cs_n_sel", dev_cs_n, exp_cs);
            end
            if (gnt !== prev_gnt) begin
                check("gnt_no_direct_switch", (prev_gnt != 0) && (gnt != 0), 0);
                if (prev_gnt == 0 && gnt != 0) begin
                    if (sb.size() > 0) check("gnt_order", gnt, onehot(sb[0].idx));
                    else check("gnt_spurious", gnt, 0);
                    if (have_done) check("gnt_gap_after_done", (cyc - last_done_cyc) >= 2, 1);
                end
            end
            if (m_start && !prev_mstart) start_cyc = cyc;
            if (done != 0 || err) begin
                if (sb.size() == 0) begin
                    check("unexpected_completion", {done, err}, 0);
                end else begin
                    e = sb.pop_front();
                    if (e.is_err) begin
                        check("err_pulse", err, 1);
                        check("no_done_on_timeout", done, 0);
                        check("err_latency", cyc - start_cyc, TMO);
                        check("rsp_hold_on_err", rsp_data, rsp_hold);
                    end else begin
                        check("no_err", err, 0);
                        check("done_onehot", done, onehot(e.idx));
                        check("gnt_at_done", gnt, onehot(e.idx));
                        check("rsp_data", rsp_data, e.rsp);
                        check("mosi_word", mosi, e.tx);
                        check("m_start_dropped", m_start, 0);
                        rsp_hold = e.rsp;
                        last_done_cyc = cyc;
                        have_done = 1'b1;
                    end
                    completions++;
                end
            end else begin
                check("rsp_held", rsp_data, rsp_hold);
            end
            prev_gnt = gnt;
            prev_mstart = m_start;
        end
    end

    task automatic wait_completion(input string name);
        int c0 = completions;
        int k  = 0;
        while (completions == c0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(name, completions != c0, 1);
    endtask

    task automatic wait_gnt(input string name);
        int k = 0;
        while (gnt == 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(name, gnt != 0, 1);
    endtask

    task automatic push_exp(input logic is_err, input int unsigned idx, input logic [DW-1:0] tx);
        exp_t x;
        x.is_err = is_err;
        x.idx    = idx;
        x.tx     = tx;
        x.rsp    = slave_of(tx);
        sb.push_back(x);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},       gnt, 0);
        check({tag, "_done"},      done, 0);
        check({tag, "_err"},       err, 0);
        check({tag, "_m_start"},   m_start, 0);
        check({tag, "_m_data_in"}, m_data_in, 0);
        check({tag, "_rsp_data"},  rsp_data, 0);
        check({tag, "_dev_cs_n"},  dev_cs_n, 4'hF);
    endtask

    vec_t          tbl [14];
    logic [DW-1:0] tx;

    initial begin
        // Expected grant index worked out by hand from the round-robin pointer
        tbl[0]  = '{4'b1111, {16'h3300, 16'h2200, 16'h1100, 16'h0F00}, 0};
        tbl[1]  = '{4'b1111, {16'h3301, 16'h2201, 16'h1101, 16'h0F01}, 1};
        tbl[2]  = '{4'b1111, {16'h3302, 16'h2202, 16'h1102, 16'h0F02}, 2};
        tbl[3]  = '{4'b1111, {16'h3303, 16'h2203, 16'h1103, 16'h0F03}, 3};
        tbl[4]  = '{4'b1111, {16'h3304, 16'h2204, 16'h1104, 16'h0F04}, 0};
        tbl[5]  = '{4'b0100, {16'h0000, 16'hA5C3, 16'h0000, 16'h0000}, 2};
        tbl[6]  = '{4'b1010, {16'h7E11, 16'h0000, 16'h6D22, 16'h0000}, 3};
        tbl[7]  = '{4'b1010, {16'h7E33, 16'h0000, 16'h6D44, 16'h0000}, 1};
        tbl[8]  = '{4'b0011, {16'h0000, 16'h0000, 16'hBEEF, 16'hCAFE}, 0};
        tbl[9]  = '{4'b1001, {16'hF00D, 16'h0000, 16'h0000, 16'h1357}, 3};
        tbl[10] = '{4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h0001}, 0};
        tbl[11] = '{4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'h8002}, 0};
        tbl[12] = '{4'b0001, {16'h0000, 16'h0000, 16'h0000, 16'hFFFF}, 0};
        tbl[13] = '{4'b0110, {16'h0000, 16'h2468, 16'h9BDF, 16'h0000}, 1};

        reset = 1'b1; req = '0; req_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 14; k++) begin
            tx = tbl[k].data[tbl[k].exp_idx*DW +: DW];
            push_exp(1'b0, tbl[k].exp_idx, tx);
            req      = tbl[k].req;
            req_data = tbl[k].data;
            wait_completion("vec_complete");
            if (k == 5) check("single_rsp_3c5a", rsp_data, 16'h3C5A);
        end
        req = '0;
        repeat (3) @(negedge clk);

        // Data changed and request dropped one cycle after grant: latched word still sent
        push_exp(1'b0, 2, 16'h5AA5);
        req_data = {16'h0000, 16'h5AA5, 16'h0000, 16'h0000};
        req      = 4'b0100;
        wait_gnt("hold_gnt_seen");
        req_data = {16'h0000, 16'hFFFF, 16'h0000, 16'h0000};
        req      = '0;
        wait_completion("hold_complete");
        repeat (3) @(negedge clk);

        // Master never responds: timeout abort
        master_dead = 1'b1;
        push_exp(1'b1, 0, 16'h0BAD);
        req_data = {16'h0000, 16'h0000, 16'h0000, 16'h0BAD};
        req      = 4'b0001;
        wait_gnt("tmo_gnt_seen");
        req = '0;
        wait_completion("tmo_complete");
        repeat (3) @(negedge clk);
        check("tmo_back_idle_gnt", gnt, 0);
        check("tmo_m_start", m_start, 0);
        check("tmo_err_cleared", err, 0);
        master_dead = 1'b0;

        // Reset in the middle of a transfer
        push_exp(1'b0, 2, 16'h7777);
        req_data = {16'h0000, 16'h7777, 16'h0000, 16'h0000};
        req      = 4'b0100;
        begin
            int k = 0;
            while (m_cs_n && k < 50) begin
                @(negedge clk);
                k++;
            end
            check("rst_xfer_reached", m_cs_n, 0);
        end
        @(negedge clk);
        reset = 1'b1;
        req   = '0;
        sb.delete();
        #2;
        check_reset_outputs("mid_rst");
        repeat (2) @(negedge clk);
        check_reset_outputs("mid_rst_hold");
        reset = 1'b0;
        @(negedge clk);
        push_exp(1'b0, 0, 16'h4321);
        req_data = {16'h8765, 16'h0000, 16'h0000, 16'h4321};
        req      = 4'b1001;
        wait_completion("post_rst_complete");
        req = '0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
